ext_ctrl_fsm: RTL and testbench

EXT_CTRL_FSM -- requirements
Module: ext_ctrl_fsm

---
 rtl/ext_ctrl_fsm.sv | 180 ++++++++++++++++++
 tb/tb_ext_ctrl_fsm.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_ctrl_fsm.sv
// rtl/ext_ctrl_fsm.sv - multicycle RISC-V style control FSM (lw, sw, R, I, beq, trap)
// Moore outputs are registered from the next state; irwrite/pcwrite/immsrc add input gating.
module ext_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       memready,
    output logic [1:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       pcwrite,
    output logic       illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_TRAP
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] alusrca_q, alusrca_d;
    logic [1:0] alusrcb_q, alusrcb_d;
    logic [1:0] aluop_q, aluop_d;
    logic [1:0] resultsrc_q, resultsrc_d;
    logic       adrsrc_q, adrsrc_d;
    logic       regwrite_q, regwrite_d;
    logic       memwrite_q, memwrite_d;
    logic       fetch_q, fetch_d;
    logic       beq_q, beq_d;
    logic       illegal_q, illegal_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (memready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (memready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (memready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase

        // Output values belong to the state being entered, so they line up with state_q next cycle.
        alusrca_d   = 2'b00;
        alusrcb_d   = 2'b00;
        aluop_d     = 2'b00;
        resultsrc_d = 2'b00;
        adrsrc_d    = 1'b0;
        regwrite_d  = 1'b0;
        memwrite_d  = 1'b0;
        fetch_d     = 1'b0;
        beq_d       = 1'b0;
        illegal_d   = illegal_q;
        case (state_d)
            S_FETCH: begin
                alusrcb_d   = 2'b10;
                resultsrc_d = 2'b10;
                fetch_d     = 1'b1;
            end
            S_DECODE: begin
                alusrca_d = 2'b01;
                alusrcb_d = 2'b01;
            end
            S_MEMADR: begin
                alusrca_d = 2'b10;
                alusrcb_d = 2'b01;
            end
            S_MEMREAD: adrsrc_d = 1'b1;
            S_MEMWB: begin
                resultsrc_d = 2'b01;
                regwrite_d  = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc_d   = 1'b1;
                memwrite_d = 1'b1;
            end
            S_EXECUTER: begin
                alusrca_d = 2'b10;
                aluop_d   = 2'b10;
            end
            S_EXECUTEI: begin
                alusrca_d = 2'b10;
                alusrcb_d = 2'b01;
                aluop_d   = 2'b10;
            end
            S_ALUWB: regwrite_d = 1'b1;
            S_BEQ: begin
                alusrca_d = 2'b10;
                aluop_d   = 2'b01;
                beq_d     = 1'b1;
            end
            S_TRAP:  illegal_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            alusrca_q   <= 2'b00;
            alusrcb_q   <= 2'b10;
            aluop_q     <= 2'b00;
            resultsrc_q <= 2'b10;
            adrsrc_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            fetch_q     <= 1'b1;
            beq_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alusrca_q   <= alusrca_d;
            alusrcb_q   <= alusrcb_d;
            aluop_q     <= aluop_d;
            resultsrc_q <= resultsrc_d;
            adrsrc_q    <= adrsrc_d;
            regwrite_q  <= regwrite_d;
            memwrite_q  <= memwrite_d;
            fetch_q     <= fetch_d;
            beq_q       <= beq_d;
            illegal_q   <= illegal_d;
        end
    end

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            default: immsrc = 2'b00;
        endcase
    end

    assign alusrca   = alusrca_q;
    assign alusrcb   = alusrcb_q;
    assign aluop     = aluop_q;
    assign resultsrc = resultsrc_q;
    assign adrsrc    = adrsrc_q;
    assign regwrite  = regwrite_q;
    assign memwrite  = memwrite_q;
    assign irwrite   = fetch_q & memready;
    assign pcwrite   = (fetch_q & memready) | (beq_q & zero);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ext_ctrl_fsm.sv
// tb/tb_ext_ctrl_fsm.sv - randomized self-checking bench for ext_ctrl_fsm
module tb_ext_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       memready;
    logic [1:0] immsrc, alusrca, alusrcb, aluop, resultsrc;
    logic       adrsrc, irwrite, regwrite, memwrite, pcwrite, illegal;

    int checks = 0;
    int errors = 0;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4;
    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                   P_MEMWRITE = 5, P_EXR = 6, P_EXI = 7, P_ALUWB = 8, P_BEQ = 9;

    ext_ctrl_fsm dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
        .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .resultsrc(resultsrc), .adrsrc(adrsrc), .irwrite(irwrite), .regwrite(regwrite),
        .memwrite(memwrite), .pcwrite(pcwrite), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] op_of(input int kind);
        case (kind)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            default: return 7'b1100011;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        return 2'b00;
    endfunction

    // Instruction timeline: fw FETCH wait cycles, then fixed steps, with mw memory wait cycles.
    function automatic int total_of(input int kind, input int fw, input int mw);
        case (kind)
            K_LW:    return 5 + fw + mw;
            K_SW:    return 4 + fw + mw;
            K_R, K_I: return 4 + fw;
            default: return 3 + fw;
        endcase
    endfunction

    function automatic int phase_of(input int kind, input int t, input int fw, input int mw);
        int s;
        if (t <= fw) return P_FETCH;
        s = t - fw;
        if (s == 1) return P_DECODE;
        case (kind)
            K_LW:    return (s == 2) ? P_MEMADR : (s <= 3 + mw) ? P_MEMREAD : P_MEMWB;
            K_SW:    return (s == 2) ? P_MEMADR : P_MEMWRITE;
            K_R:     return (s == 2) ? P_EXR : P_ALUWB;
            K_I:     return (s == 2) ? P_EXI : P_ALUWB;
            default: return P_BEQ;
        endcase
    endfunction

    // {alusrca, alusrcb, aluop, resultsrc, adrsrc, irwrite, regwrite, memwrite, pcwrite}
    function automatic logic [12:0] exp_vec(input int phase, input logic mr, input logic z);
        case (phase)
            P_FETCH:    return {2'b00, 2'b10, 2'b00, 2'b10, 1'b0, mr, 1'b0, 1'b0, mr};
            P_DECODE:   return {2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            P_MEMADR:   return {2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            P_MEMREAD:  return {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            P_MEMWB:    return {2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            P_MEMWRITE: return {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            P_EXR:      return {2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            P_EXI:      return {2'b10, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            P_ALUWB:    return {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            P_BEQ:      return {2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, z};
            default:    return 13'd0;
        endcase
    endfunction

    task automatic release_reset();
        memready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_instr(input string name, input int kind, input int fw, input int mw,
                             input int zsel);
        int          total, phase, s;
        logic        mr, z;
        logic [12:0] expv, actv;
        total = total_of(kind, fw, mw);
        for (int t = 0; t < total; t++) begin
            @(negedge clk);
            phase = phase_of(kind, t, fw, mw);
            s = t - fw - 3;
            if (phase == P_FETCH) mr = (t == fw);
            else if (phase == P_MEMREAD || phase == P_MEMWRITE) mr = (s >= mw);
            else mr = 1'($urandom_range(0, 1));
            z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            op = op_of(kind);
            memready = mr;
            zero = z;
            #1;
            expv = exp_vec(phase, mr, z);
            actv = {alusrca, alusrcb, aluop, resultsrc, adrsrc, irwrite, regwrite, memwrite, pcwrite};
            checks++;
            if (actv !== expv) begin
                errors++;
                $display("FAIL %s t=%0d outputs actual=%b required=%b", name, t, actv, expv);
            end
            checks++;
            if (immsrc !== exp_imm(op)) begin
                errors++;
                $display("FAIL %s t=%0d immsrc actual=%b required=%b", name, t, immsrc, exp_imm(op));
            end
            checks++;
            if ($countones({regwrite, memwrite, irwrite}) > 1) begin
                errors++;
                $display("FAIL %s t=%0d exclusive_writes actual=%b%b%b required=at_most_one",
                         name, t, regwrite, memwrite, irwrite);
            end
            checks++;
            if (illegal !== 1'b0) begin
                errors++;
                $display("FAIL %s t=%0d illegal actual=%b required=0", name, t, illegal);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        memready = 1'b0;
        zero = 1'b0;
        op = 7'b0000011;
        @(negedge clk);
        checks++;
        if ({alusrca, alusrcb, aluop, resultsrc, adrsrc, irwrite, regwrite, memwrite, pcwrite, illegal}
            !== {2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state actual=%b %b %b %b %b %b%b%b%b %b required=00 10 00 10 0 0000 0",
                     alusrca, alusrcb, aluop, resultsrc, adrsrc, irwrite, regwrite, memwrite, pcwrite, illegal);
        end
        memready = 1'b1;
        #1;
        checks++;
        if ({irwrite, pcwrite} !== 2'b11) begin
            errors++;
            $display("FAIL reset_fetch_gating actual=%b%b required=11", irwrite, pcwrite);
        end
        release_reset();
    endtask

    task automatic test_directed();
        run_instr("lw", K_LW, 0, 0, -1);
        run_instr("sw_wait2", K_SW, 0, 2, -1);
        run_instr("beq_taken", K_BEQ, 0, 0, 1);
        run_instr("beq_not_taken", K_BEQ, 0, 0, 0);
        run_instr("r_type", K_R, 1, 0, -1);
        run_instr("i_type", K_I, 0, 0, -1);
        run_instr("lw_waits", K_LW, 2, 2, -1);
    endtask

    task automatic test_random_stream();
        int kind, fw, mw;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 4));
            fw = int'($urandom_range(0, 2));
            mw = int'($urandom_range(0, 2));
            run_instr("random", kind, fw, mw, -1);
        end
        @(negedge clk);
        memready = 1'b0;
        #1;
        checks++;
        if ({alusrcb, resultsrc, irwrite} !== 5'b10100) begin
            errors++;
            $display("FAIL random_end_fetch actual=%b required=10100", {alusrcb, resultsrc, irwrite});
        end
    endtask

    task automatic test_trap();
        logic [12:0] actv;
        @(negedge clk);
        op = 7'b1111111;
        memready = 1'b1;
        #1;
        checks++;
        if ({irwrite, pcwrite, immsrc} !== 4'b1100) begin
            errors++;
            $display("FAIL trap_fetch actual=%b required=1100", {irwrite, pcwrite, immsrc});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({alusrca, alusrcb, illegal} !== 5'b01010) begin
            errors++;
            $display("FAIL trap_decode actual=%b required=01010", {alusrca, alusrcb, illegal});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            memready = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            #1;
            actv = {alusrca, alusrcb, aluop, resultsrc, adrsrc, irwrite, regwrite, memwrite, pcwrite};
            checks++;
            if (illegal !== 1'b1 || actv !== 13'd0) begin
                errors++;
                $display("FAIL trap_hold cycle=%0d illegal=%b outputs=%b required illegal=1 outputs=0",
                         i, illegal, actv);
            end
        end
        memready = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({illegal, alusrcb, resultsrc} !== 5'b01010) begin
            errors++;
            $display("FAIL trap_reset actual=%b required=01010", {illegal, alusrcb, resultsrc});
        end
        release_reset();
        run_instr("after_trap", K_I, 0, 0, -1);
    endtask

    task automatic test_reset_midwrite();
        run_instr("sw_pre", K_SW, 0, 5, -1);
        reset = 1'b1;
        release_reset();
        @(negedge clk);
        op = 7'b0100011;
        memready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        memready = 1'b0;
        #1;
        checks++;
        if (memwrite !== 1'b1) begin
            errors++;
            $display("FAIL midwrite_wait actual=%b required=1", memwrite);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({memwrite, regwrite, irwrite, pcwrite, alusrcb, resultsrc} !== 8'b00001010) begin
            errors++;
            $display("FAIL midwrite_reset actual=%b required=00001010",
                     {memwrite, regwrite, irwrite, pcwrite, alusrcb, resultsrc});
        end
        @(posedge clk);
        #1;
        checks++;
        if (memwrite !== 1'b0) begin
            errors++;
            $display("FAIL midwrite_reset_edge actual=%b required=0", memwrite);
        end
        release_reset();
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_lw", K_LW, 0, 0, -1);
        run_instr("b2b_sw", K_SW, 0, 0, -1);
        run_instr("b2b_beq", K_BEQ, 0, 0, -1);
        run_instr("b2b_r", K_R, 0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_stream();
        test_trap();
        test_reset_midwrite();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
